// File: rtl/psum_drain.sv
// psum_drain: captures one LANES-wide partial-sum vector and streams it out one lane per cycle (optional ReLU via PSUM_RELU_EN); ports clk/rst, in_valid/in_ready/in_data, out_valid/out_ready/out_data/out_idx/out_last, busy, vec_cnt
module psum_drain #(
  parameter int DW    = 20,
  parameter int LANES = 10,
  parameter int IDX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic [15:0]           vec_cnt
);
  typedef enum logic {IDLE, DRAIN} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);
  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [LANES-1:0][DW-1:0] buf_q, buf_d;
  logic [15:0]              vec_cnt_q, vec_cnt_d;
  logic [DW-1:0]            out_data_q, out_data_d, lane;
  logic [IDX_W-1:0]         out_idx_q;
  logic                     out_last_q;
  logic                     out_fire, last_fire, in_fire;
  assign out_fire  = (state_q == DRAIN) & out_ready;
  assign last_fire = out_fire & (ptr_q == LAST);
  // the last-lane handshake frees the buffer in the same cycle, so the next vector loads without a bubble
  assign in_ready  = (state_q == IDLE) | last_fire;
  assign in_fire   = in_valid & in_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      buf_q      <= '0;
      vec_cnt_q  <= '0;
      out_data_q <= '0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      buf_q      <= buf_d;
      vec_cnt_q  <= vec_cnt_d;
      out_data_q <= out_data_d;
      out_idx_q  <= ptr_d;
      out_last_q <= (ptr_d == LAST);
    end
  end
  always_comb begin
    state_d   = in_fire ? DRAIN : last_fire ? IDLE : state_q;
    ptr_d     = (in_fire | last_fire) ? '0 : out_fire ? ptr_q + IDX_W'(1) : ptr_q;
    buf_d     = in_fire ? in_data : buf_q;
    vec_cnt_d = last_fire ? vec_cnt_q + 16'd1 : vec_cnt_q;
  end
  // output registers are loaded from next-state values so they line up with ptr
  always_comb begin
    lane = buf_d[ptr_d];
`ifdef PSUM_RELU_EN
    out_data_d = lane[DW-1] ? '0 : lane;
`else
    out_data_d = lane;
`endif
  end
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == DRAIN);
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign vec_cnt   = vec_cnt_q;
endmodule

// File: doc/psum_drain.md
# psum_drain

Output-side reader for the PE array's partial-sum register stage. Captures one vector of LANES parallel partial sums with a valid/ready handshake, then streams the lanes out one per cycle on a valid/ready serial port toward the output buffer/SRAM writer. Supports back-to-back vectors with no bubble cycle, and counts completed vectors for the controller.

## Interface
Parameters:
- DW, 20, partial-sum width in bits (two's complement)
- LANES, 10, lanes per vector
- IDX_W, 4, lane index width (must satisfy 2^IDX_W ≥ LANES)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  in_data holds a valid vector
- in_ready  out  1  block accepts the vector this cycle
- in_data  in  LANES*DW  lane k at bits [k*DW +: DW]; lane 0 corresponds to the array's first output
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- out_data  out  DW  current lane value
- out_idx  out  IDX_W  index of the current lane
- out_last  out  1  high with lane LANES-1
- busy  out  1  a vector is held or draining
- vec_cnt  out  16  completed vectors since reset, wraps at 65535→0

## Operation
- State machine has two states:
  - IDLE: no vector held.
  - DRAIN: vector buffer valid; lane pointer ptr selects the output lane.
- Input handshake: a vector is accepted when in_valid & in_ready.
  - On accept, all lanes are stored in the buffer, ptr←0, and the state becomes DRAIN.
- in_ready = (state==IDLE) | (state==DRAIN & out_valid & out_ready & ptr==LANES-1).
  - in_ready is combinational on out_ready. This is intentional and keeps back-to-back streaming bubble-free.
- Outputs in DRAIN:
  - out_valid=1
  - out_data = buffer lane ptr
  - out_idx = ptr
  - out_last = (ptr==LANES-1)
- Each out_valid & out_ready: ptr←ptr+1.
- On accepting the last lane:
  - vec_cnt increments.
  - If a new vector is accepted in the same cycle, the buffer reloads, ptr←0, and the state stays DRAIN.
  - Otherwise the state returns to IDLE.
- While out_valid & !out_ready, out_data/out_idx/out_last stay stable and ptr holds.
- in_valid while in_ready=0 is ignored. The upstream holds its data.
- busy = (state==DRAIN).
- Reset values: state IDLE, ptr 0, buffer 0, out_valid 0, out_data 0, out_idx 0, out_last 0, busy 0, vec_cnt 0. in_ready is 1 after reset.
- Reset asserted mid-drain immediately discards the held vector: out_valid drops asynchronously and no partial count is recorded.

## Timing
- Latency: a vector accepted at edge N presents lane 0 with out_valid=1 in the cycle after edge N.
- Throughput: with out_ready held high, one lane per cycle and LANES cycles per vector.
  - Consecutive vectors stream with zero idle cycles.
  - The lane-(LANES-1) handshake and the next input handshake share one edge.
- vec_cnt updates on the edge that completes the last-lane handshake, and is visible the following cycle.
- All outputs are registered except in_ready.

## Configuration
- PSUM_RELU_EN:
  - Defined: out_data = 0 when the buffered lane's MSB is 1 (negative); otherwise the lane value unchanged. The clamp is applied on the output mux; buffer contents are unaffected.
  - Undefined: out_data is the raw buffered lane value.
  - out_idx, handshakes and timing are identical either way.

## Test plan
- Reset then single vector:
  - Stimulus: lanes 1..10 (lane k = k+1), out_ready=1.
  - Required: out_data 1,2,…,10 on 10 consecutive cycles starting the cycle after accept; out_idx 0..9; out_last only with 10; vec_cnt=1; busy falls after the last lane.
- Back-to-back:
  - Stimulus: two vectors (1..10, then 11..20), in_valid held, out_ready=1.
  - Required: 20 consecutive out_valid cycles with no gap; second accept on the same edge as lane 9 of the first; vec_cnt=2.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles while lane 4 (value 5) is presented.
  - Required: out_data=5 and out_idx=4 held stable for all 3 cycles; in_ready=0 throughout; sequence resumes with 6.
- Reset mid-drain:
  - Stimulus: assert rst asynchronously after lane 3 is consumed.
  - Required: out_valid=0 and busy=0 immediately; vec_cnt=0; after release, a new vector drains from lane 0.
- ReLU (PSUM_RELU_EN defined):
  - Stimulus: lane values 20'hFFFFF (−1), 20'h7FFFF, 0, 20'h80000.
  - Required: outputs 0, 20'h7FFFF, 0, 0.
  - With the macro undefined: the same values pass unchanged.
- Counter wrap:
  - Stimulus: preload vec_cnt via force to 65535, then drain one vector.
  - Required: vec_cnt reads 0 afterwards.
